// File: rtl/apb_regbank.sv
// APB3 completer holding NUM_REGS 32-bit registers at BASE_ADDR, with programmable
// wait states, PSLVERR on bad or read-only writes, and per-register write pulses.
module apb_regbank #(
  parameter logic [31:0]         BASE_ADDR   = 32'h8c000000,
  parameter int                  NUM_REGS    = 16,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter logic [31:0]         RESET_VALUE = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [31:0]              PADDR,
  input  logic [31:0]              PWDATA,
  output logic [31:0]              PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  input  logic [NUM_REGS*32-1:0]   status_in,
  output logic [NUM_REGS*32-1:0]   regs_out,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              dec_valid_q;
  logic [IDX_W-1:0]  dec_idx_q;

  logic [31:0]       offset;
  logic              addr_valid;
  logic [IDX_W-1:0]  addr_idx;
  logic              setup;
  logic              complete;
  logic              ro_hit;
  logic              xfer_err;
  logic              commit;
  logic [31:0]       rd_word;
  logic [31:0]       regs_q   [NUM_REGS];
  logic [31:0]       status_w [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;

  // Unsigned offset: addresses below BASE_ADDR wrap high and fail the range test.
  assign offset     = PADDR - BASE_ADDR;
  assign addr_valid = (PADDR >= BASE_ADDR) && (offset[1:0] == 2'b00) &&
                      ({2'b00, offset[31:2]} < 32'(NUM_REGS));
  assign addr_idx   = offset[IDX_W+1:2];

  assign setup    = (state_q == IDLE) && PSEL && !PENABLE;
  assign PREADY   = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign complete = PSEL && PENABLE && PREADY;
  assign ro_hit   = RO_MASK[dec_idx_q];
  assign xfer_err = !dec_valid_q || (PWRITE && ro_hit);
  assign commit   = complete && PWRITE && !xfer_err;

  assign rd_word = ro_hit ? status_w[dec_idx_q] : regs_q[dec_idx_q];
  assign PRDATA  = (PREADY && !PWRITE && dec_valid_q) ? rd_word : 32'h0;
  assign PSLVERR = PREADY && xfer_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (complete) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control: FSM, wait counter and decode captured in the setup phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      dec_valid_q <= 1'b0;
      dec_idx_q   <= '0;
      wr_pulse    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_pulse <= wr_hit;
      if (setup) begin
        dec_valid_q <= addr_valid;
        dec_idx_q   <= addr_idx;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign status_w[i] = status_in[32*i +: 32];
    assign wr_hit[i]   = commit && (dec_idx_q == IDX_W'(i));
    if (RO_MASK[i]) begin : g_ro
      assign regs_q[i] = 32'h0;
    end else begin : g_rw
      logic [31:0] q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          q <= RESET_VALUE;
        else if (wr_hit[i])
          q <= PWDATA;
      end
      assign regs_q[i] = q;
    end
    assign regs_out[32*i +: 32] = regs_q[i];
  end

endmodule

// File: tb/tb_apb_regbank.sv
// Directed bench for apb_regbank: a zero-wait bank with a read-only slot and a
// 3-wait-state bank, expected responses queued per transfer and checked on PREADY.
module tb_apb_regbank;

  localparam logic [31:0] BASE = 32'h8c000000;
  localparam logic [31:0] RV_B = 32'hA5A50000;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          psel;
  logic                penable, pwrite;
  logic [31:0]         paddr, pwdata;
  logic [31:0]         prdata [2];
  logic [1:0]          pready, pslverr;
  logic [16*32-1:0]    status_a, regs_a;
  logic [4*32-1:0]     status_b, regs_b;
  logic [15:0]         wrp_a;
  logic [3:0]          wrp_b;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          waits;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_a [16];
  logic [31:0] m_b [4];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  apb_regbank #(
    .BASE_ADDR(BASE), .NUM_REGS(16), .WAIT_STATES(0),
    .RO_MASK(16'h0004), .RESET_VALUE(32'h0)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .status_in(status_a), .regs_out(regs_a), .wr_pulse(wrp_a)
  );

  apb_regbank #(
    .BASE_ADDR(BASE), .NUM_REGS(4), .WAIT_STATES(3),
    .RO_MASK(4'h0), .RESET_VALUE(RV_B)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .status_in(status_b), .regs_out(regs_b), .wr_pulse(wrp_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) check({tag, "_regs_a"}, regs_a[32*i +: 32], m_a[i]);
    for (int i = 0; i < 4; i++)  check({tag, "_regs_b"}, regs_b[32*i +: 32], m_b[i]);
  endtask

  task automatic reset_models();
    for (int i = 0; i < 16; i++) m_a[i] = 32'h0;
    for (int i = 0; i < 4; i++)  m_b[i] = RV_B;
  endtask

  // One complete APB transfer on bank d; expectation queued before driving.
  task automatic xfer(input string step, input int d, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_waits);
    exp_t e;
    int   waits;
    logic done;
    sb_q.push_back('{exp_rd, exp_err, exp_waits});
    @(posedge clk); #1;
    psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (pready[d]) begin
        done = 1'b1;
        e = sb_q.pop_front();
        check({step, "_rdata"}, prdata[d], e.rd);
        check({step, "_pslverr"}, {31'b0, pslverr[d]}, {31'b0, e.err});
        check({step, "_waits"}, 32'(waits), 32'(e.waits));
      end else begin
        waits++;
        check({step, "_wait_err"}, {31'b0, pslverr[d]}, 32'h0);
        check({step, "_wait_rdata"}, prdata[d], 32'h0);
        @(posedge clk); #1;
      end
    end
    check({step, "_completed"}, {31'b0, done}, 32'h1);
    if (!done) e = sb_q.pop_front();
    @(posedge clk); #1;
    psel[d] = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1);
  end

  initial begin
    psel = 2'b00; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) status_a[32*i +: 32] = 32'hF00D0000 | 32'(i);
    status_a[64 +: 32] = 32'h00001234;
    status_b = {4{32'h5555AAAA}};
    reset_models();

    // Reset state
    #12;
    check("rst_pready", {30'b0, pready}, 32'h0);
    check("rst_pslverr", {30'b0, pslverr}, 32'h0);
    check("rst_prdata_a", prdata[0], 32'h0);
    check("rst_prdata_b", prdata[1], 32'h0);
    check("rst_wrp", {12'b0, wrp_b, wrp_a}, 32'h0);
    check_regs("rst");
    @(negedge clk); rst_n = 1'b1;

    // Zero-wait write, pulse, read-back
    xfer("wr1", 0, 1'b1, BASE + 32'h4, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    m_a[1] = 32'hDEADBEEF;
    @(negedge clk); check("wr1_pulse", {16'b0, wrp_a}, 32'h0002);
    @(negedge clk); check("wr1_pulse_end", {16'b0, wrp_a}, 32'h0);
    check_regs("wr1");
    xfer("rd1", 0, 1'b0, BASE + 32'h4, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    // Bad addresses
    xfer("rd_unal", 0, 1'b0, BASE + 32'h2, 32'h0, 32'h0, 1'b1, 0);
    xfer("wr_oob", 0, 1'b1, BASE + 32'h40, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
    @(negedge clk); check("wr_oob_pulse", {16'b0, wrp_a}, 32'h0);
    xfer("rd_oob", 0, 1'b0, BASE + 32'h40, 32'h0, 32'h0, 1'b1, 0);
    xfer("rd_below", 0, 1'b0, BASE - 32'h4, 32'h0, 32'h0, 1'b1, 0);
    xfer("wr_unal", 0, 1'b1, BASE + 32'h5, 32'h13572468, 32'h0, 1'b1, 0);
    check_regs("bad");

    // Read-only status slot
    xfer("rd_ro", 0, 1'b0, BASE + 32'h8, 32'h0, 32'h00001234, 1'b0, 0);
    xfer("wr_ro", 0, 1'b1, BASE + 32'h8, 32'h55555555, 32'h0, 1'b1, 0);
    @(negedge clk); check("wr_ro_pulse", {16'b0, wrp_a}, 32'h0);
    status_a[64 +: 32] = 32'h0000ABCD;
    xfer("rd_ro2", 0, 1'b0, BASE + 32'h8, 32'h0, 32'h0000ABCD, 1'b0, 0);
    check_regs("ro");

    // Last register
    xfer("wr_last", 0, 1'b1, BASE + 32'h3C, 32'h11223344, 32'h0, 1'b0, 0);
    m_a[15] = 32'h11223344;
    @(negedge clk); check("wr_last_pulse", {16'b0, wrp_a}, 32'h8000);
    xfer("rd_last", 0, 1'b0, BASE + 32'h3C, 32'h0, 32'h11223344, 1'b0, 0);
    xfer("rd_r0", 0, 1'b0, BASE, 32'h0, 32'h0, 1'b0, 0);

    // PENABLE without a setup phase is ignored
    @(posedge clk); #1;
    psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = BASE + 32'h4; pwdata = 32'h5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check("nosetup_rdy", {31'b0, pready[0]}, 32'h0);
    end
    @(posedge clk); #1; psel[0] = 1'b0; penable = 1'b0;
    @(negedge clk); check("nosetup_pulse", {16'b0, wrp_a}, 32'h0);
    check_regs("nosetup");

    // Three wait states
    xfer("b_rd0", 1, 1'b0, BASE, 32'h0, RV_B, 1'b0, 3);
    xfer("b_wr3", 1, 1'b1, BASE + 32'hC, 32'hCAFEF00D, 32'h0, 1'b0, 3);
    m_b[3] = 32'hCAFEF00D;
    @(negedge clk); check("b_wr3_pulse", {28'b0, wrp_b}, 32'h8);
    @(negedge clk); check("b_wr3_pulse_end", {28'b0, wrp_b}, 32'h0);
    xfer("b_rd3", 1, 1'b0, BASE + 32'hC, 32'h0, 32'hCAFEF00D, 1'b0, 3);
    xfer("b_oob", 1, 1'b0, BASE + 32'h10, 32'h0, 32'h0, 1'b1, 3);
    check_regs("b");

    // PSEL dropped during wait states
    @(posedge clk); #1;
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h4; pwdata = 32'h77;
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk); check("abort_wait", {31'b0, pready[1]}, 32'h0);
    @(posedge clk); #1; psel[1] = 1'b0; penable = 1'b0;
    @(negedge clk); check("abort_rdy", {31'b0, pready[1]}, 32'h0);
    @(negedge clk); check("abort_pulse", {28'b0, wrp_b}, 32'h0);
    check_regs("abort");
    xfer("abort_rd", 1, 1'b0, BASE + 32'h4, 32'h0, RV_B, 1'b0, 3);

    // Reset pulsed mid-access
    @(posedge clk); #1;
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h8; pwdata = 32'h99;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #2; rst_n = 1'b0; #1;
    reset_models();
    check("mrst_rdy", {30'b0, pready}, 32'h0);
    check("mrst_wrp", {12'b0, wrp_b, wrp_a}, 32'h0);
    check_regs("mrst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("mrst_idle", {31'b0, pready[1]}, 32'h0);
    psel[1] = 1'b0; penable = 1'b0;
    xfer("mrst_rd_b", 1, 1'b0, BASE + 32'h8, 32'h0, RV_B, 1'b0, 3);
    xfer("mrst_rd_a", 0, 1'b0, BASE + 32'h4, 32'h0, 32'h0, 1'b0, 0);
    check_regs("end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
